// File: rtl/control_pkg.sv
// Shared definitions for the registered control sequencer: opcode map,
// PC/write-back source encodings, FSM state type and the decoded flag bundle.
package control_pkg;

  localparam logic [1:0] PC_SRC_NEXT  = 2'b00;
  localparam logic [1:0] PC_SRC_B_IMM = 2'b01;
  localparam logic [1:0] PC_SRC_B_REG = 2'b10;

  localparam logic [1:0] W_SRC_ALU     = 2'b00;
  localparam logic [1:0] W_SRC_RAM     = 2'b01;
  localparam logic [1:0] W_SRC_PC_NEXT = 2'b10;

  localparam logic [3:0] OP_ALU  = 4'd0;
  localparam logic [3:0] OP_ALUI = 4'd1;
  localparam logic [3:0] OP_LW   = 4'd2;
  localparam logic [3:0] OP_SW   = 4'd3;
  localparam logic [3:0] OP_B    = 4'd4;
  localparam logic [3:0] OP_BR   = 4'd5;

  localparam logic [3:0] ALU_ADD = 4'b0010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MEM,
    ST_FAULT
  } state_t;

  // Controls captured at instruction acceptance; branch resolution is
  // already folded in, so a not-taken branch arrives here as all zeros.
  typedef struct packed {
    logic       regs_we;
    logic       ram_rd;
    logic       ram_we;
    logic       d_or_b;
    logic       imm16;
    logic [1:0] pc_src;
    logic [1:0] wdata_src;
    logic       flush;
  } ctl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode/opfunc/adata_zero to control-flag table, including
// branch condition evaluation. No state lives here.
module control_decode
  import control_pkg::*;
#(
  parameter int OPFUNC_W = 4
) (
  input  logic [3:0]          opcode,
  input  logic [OPFUNC_W-1:0] opfunc,
  input  logic                adata_zero,
  output ctl_t                ctl,
  output logic [OPFUNC_W-1:0] alu_func,
  output logic                illegal
);

  logic taken_cond;

  // Condition bits: [0]&[1] always, [0] on Ra==0, [1] on Ra!=0.
  assign taken_cond = (opfunc[0] & opfunc[1]) |
                      (opfunc[0] & adata_zero) |
                      (opfunc[1] & ~adata_zero);

  // Flag table; unlisted opcodes decode as a NOP flagged illegal.
  always_comb begin
    ctl      = '0;
    alu_func = opfunc;
    illegal  = 1'b0;
    case (opcode)
      OP_ALU: begin
        ctl.regs_we = 1'b1;
      end
      OP_ALUI: begin
        ctl.regs_we = 1'b1;
        ctl.d_or_b  = 1'b1;
        ctl.imm16   = 1'b1;
      end
      OP_LW: begin
        ctl.regs_we = 1'b1;
        ctl.ram_rd  = 1'b1;
        ctl.d_or_b  = 1'b1;
        ctl.imm16   = 1'b1;
        alu_func    = OPFUNC_W'(ALU_ADD);
      end
      OP_SW: begin
        ctl.ram_we = 1'b1;
        ctl.imm16  = 1'b1;
        alu_func   = OPFUNC_W'(ALU_ADD);
      end
      OP_B, OP_BR: begin
        if (taken_cond) begin
          ctl.regs_we   = opfunc[3];
          ctl.d_or_b    = (opcode == OP_B);
          ctl.imm16     = 1'b1;
          ctl.pc_src    = (opcode == OP_B) ? PC_SRC_B_IMM : PC_SRC_B_REG;
          ctl.wdata_src = W_SRC_PC_NEXT;
          ctl.flush     = 1'b1;
        end else begin
          alu_func = '0;
        end
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_seq.sv
// Registered multi-cycle control sequencer between fetch and the datapath.
// Accepts one instruction per handshake, holds memory controls across RAM
// wait states and latches a sticky fault when the wait bound expires.
// Optional: define CONTROL_SEQ_ILLEGAL_TRAP_EN to send illegal opcodes to
// FAULT instead of executing them as NOPs.
module control_seq
  import control_pkg::*;
#(
  parameter int OPFUNC_W = 4,
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          opcode,
  input  logic [OPFUNC_W-1:0] opfunc,
  input  logic                adata_zero,
  input  logic                ram_ack,
  output logic                out_valid,
  output logic                ctl_regs_we,
  output logic                ctl_ram_rd,
  output logic                ctl_ram_we,
  output logic                ctl_d_or_b,
  output logic                ctl_imm16,
  output logic [1:0]          ctl_pc_src,
  output logic [1:0]          ctl_wdata_src,
  output logic [OPFUNC_W-1:0] ctl_alu_func,
  output logic                flush,
  output logic                fault
);

`ifdef CONTROL_SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

  state_t              state_q, state_d;
  ctl_t                ctl_q, ctl_d;
  logic [OPFUNC_W-1:0] alu_q, alu_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;

  ctl_t                dec_ctl;
  logic [OPFUNC_W-1:0] dec_alu;
  logic                dec_illegal;
  logic                is_mem;

  control_decode #(
    .OPFUNC_W (OPFUNC_W)
  ) u_decode (
    .opcode     (opcode),
    .opfunc     (opfunc),
    .adata_zero (adata_zero),
    .ctl        (dec_ctl),
    .alu_func   (dec_alu),
    .illegal    (dec_illegal)
  );

  assign is_mem = ctl_q.ram_rd | ctl_q.ram_we;

  // Next state: capture decode on accept, one EXEC cycle, bounded MEM wait.
  always_comb begin
    state_d = state_q;
    ctl_d   = ctl_q;
    alu_d   = alu_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          ctl_d   = dec_ctl;
          alu_d   = dec_alu;
          cnt_d   = '0;
          state_d = (dec_illegal && TRAP_EN) ? ST_FAULT : ST_EXEC;
        end
      end
      ST_EXEC: begin
        cnt_d   = '0;
        state_d = is_mem ? ST_MEM : ST_IDLE;
      end
      ST_MEM: begin
        if (ram_ack) begin
          state_d = ST_IDLE;
        end else if (cnt_q == LAST_WAIT) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: registered controls gated by state; LW write-back opens on ack.
  always_comb begin
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    ctl_regs_we   = 1'b0;
    ctl_ram_rd    = 1'b0;
    ctl_ram_we    = 1'b0;
    ctl_d_or_b    = 1'b0;
    ctl_imm16     = 1'b0;
    ctl_pc_src    = PC_SRC_NEXT;
    ctl_wdata_src = W_SRC_ALU;
    ctl_alu_func  = '0;
    flush         = 1'b0;
    fault         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_EXEC: begin
        out_valid     = 1'b1;
        ctl_regs_we   = ctl_q.regs_we & ~is_mem;
        ctl_ram_rd    = ctl_q.ram_rd;
        ctl_ram_we    = ctl_q.ram_we;
        ctl_d_or_b    = ctl_q.d_or_b;
        ctl_imm16     = ctl_q.imm16;
        ctl_pc_src    = ctl_q.pc_src;
        ctl_wdata_src = ctl_q.wdata_src;
        ctl_alu_func  = alu_q;
        flush         = ctl_q.flush;
      end
      ST_MEM: begin
        out_valid    = 1'b1;
        ctl_ram_rd   = ctl_q.ram_rd;
        ctl_ram_we   = ctl_q.ram_we;
        ctl_d_or_b   = ctl_q.d_or_b;
        ctl_imm16    = ctl_q.imm16;
        ctl_alu_func = alu_q;
        if (ctl_q.ram_rd && ram_ack) begin
          ctl_regs_we   = 1'b1;
          ctl_wdata_src = W_SRC_RAM;
        end
      end
      ST_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // State, captured controls and wait counter; reset aborts any access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ctl_q   <= '0;
      alu_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      alu_q   <= alu_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_control_seq.sv
// Scoreboard bench for control_seq: stimulus pushes expected control words,
// a negedge monitor pops one per out_valid cycle. Honours
// CONTROL_SEQ_ILLEGAL_TRAP_EN for the illegal-opcode case.
module tb_control_seq;
  import control_pkg::*;

  localparam int OPFUNC_W = 4;
  localparam int WAIT_W   = 4;
  localparam int MAX_WAIT = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] opcode = '0;
  logic [3:0] opfunc = '0;
  logic       adata_zero = 1'b0;
  logic       ram_ack = 1'b0;
  logic       in_ready, out_valid, ctl_regs_we, ctl_ram_rd, ctl_ram_we;
  logic       ctl_d_or_b, ctl_imm16, flush, fault;
  logic [1:0] ctl_pc_src, ctl_wdata_src;
  logic [3:0] ctl_alu_func;

  typedef struct {
    string       name;
    logic [13:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   vec_cnt  = 0;
  int   miss_cnt = 0;

  control_seq #(
    .OPFUNC_W (OPFUNC_W),
    .WAIT_W   (WAIT_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .opcode        (opcode),
    .opfunc        (opfunc),
    .adata_zero    (adata_zero),
    .ram_ack       (ram_ack),
    .out_valid     (out_valid),
    .ctl_regs_we   (ctl_regs_we),
    .ctl_ram_rd    (ctl_ram_rd),
    .ctl_ram_we    (ctl_ram_we),
    .ctl_d_or_b    (ctl_d_or_b),
    .ctl_imm16     (ctl_imm16),
    .ctl_pc_src    (ctl_pc_src),
    .ctl_wdata_src (ctl_wdata_src),
    .ctl_alu_func  (ctl_alu_func),
    .flush         (flush),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [13:0] act_word();
    return {ctl_regs_we, ctl_ram_rd, ctl_ram_we, ctl_d_or_b, ctl_imm16,
            ctl_pc_src, ctl_wdata_src, ctl_alu_func, flush};
  endfunction

  task automatic push_exp(input string name, input logic we, input logic rd,
                          input logic wr, input logic dob, input logic imm,
                          input logic [1:0] pc, input logic [1:0] ws,
                          input logic [3:0] alu, input logic fl);
    exp_t e;
    e.name = name;
    e.v    = {we, rd, wr, dob, imm, pc, ws, alu, fl};
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    vec_cnt++;
    if (act !== req) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // in_ready, out_valid, fault and the whole control word in one comparison.
  task automatic check_status(input string name, input logic rdy, input logic flt);
    checkOutput(name, {15'b0, in_ready, out_valid, fault, act_word()},
                {15'b0, rdy, 1'b0, flt, 14'b0});
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [3:0] fn,
                               input logic az);
    @(posedge clk);
    #1;
    in_valid   = 1'b1;
    opcode     = op;
    opfunc     = fn;
    adata_zero = az;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    opcode     = 4'($urandom);
    opfunc     = 4'($urandom);
    adata_zero = 1'($urandom);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'b0, in_ready}, 32'd1);
  endtask

  // Monitor: every out_valid cycle must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && out_valid) begin
      vec_cnt++;
      if (exp_q.size() == 0) begin
        miss_cnt++;
        $display("[TB] FAIL unexpected_out: got %h required no output", act_word());
      end else begin
        e = exp_q.pop_front();
        if (act_word() !== e.v) begin
          miss_cnt++;
          $display("[TB] FAIL %s: got %h required %h", e.name, act_word(), e.v);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_status("reset_state", 1'b1, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // ALU reg: out_valid the cycle after accept, ready again one cycle later
    push_exp("alu_reg", 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'd5, 0);
    applyStimulus(OP_ALU, 4'd5, 1'b0);
    @(negedge clk);
    checkOutput("alu_reg_busy", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    check_status("alu_reg_idle", 1'b1, 1'b0);

    push_exp("alu_imm", 1, 0, 0, 1, 1, 2'b00, 2'b00, 4'hA, 0);
    applyStimulus(OP_ALUI, 4'hA, 1'b0);
    wait_ready("alu_imm_ready");

    // Taken relative branch with link, flush only for one cycle
    push_exp("b_imm_taken", 1, 0, 0, 1, 1, 2'b01, 2'b10, 4'b1001, 1);
    applyStimulus(OP_B, 4'b1001, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check_status("flush_pulse_end", 1'b1, 1'b0);

    push_exp("b_imm_not_taken", 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'd0, 0);
    applyStimulus(OP_B, 4'b1001, 1'b0);
    wait_ready("b_not_ready");

    push_exp("br_taken", 0, 0, 0, 0, 1, 2'b10, 2'b10, 4'b0011, 1);
    applyStimulus(OP_BR, 4'b0011, 1'b0);
    wait_ready("br_taken_ready");

    push_exp("br_not_taken", 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'd0, 0);
    applyStimulus(OP_BR, 4'b0110, 1'b1);
    wait_ready("br_not_ready");

    // LW with ack on the third MEM cycle
    repeat (3) push_exp("lw_wait", 0, 1, 0, 1, 1, 2'b00, 2'b00, ALU_ADD, 0);
    push_exp("lw_ack", 1, 1, 0, 1, 1, 2'b00, 2'b01, ALU_ADD, 0);
    applyStimulus(OP_LW, 4'd7, 1'b0);
    repeat (3) @(posedge clk);
    #1 ram_ack = 1'b1;
    @(posedge clk);
    #1 ram_ack = 1'b0;
    @(negedge clk);
    check_status("lw_done", 1'b1, 1'b0);

    // SW: ack during EXEC is ignored, ack in second MEM cycle completes
    repeat (3) push_exp("sw_exec_ack", 0, 0, 1, 0, 1, 2'b00, 2'b00, ALU_ADD, 0);
    applyStimulus(OP_SW, 4'hC, 1'b0);
    ram_ack = 1'b1;
    @(posedge clk);
    #1 ram_ack = 1'b0;
    @(posedge clk);
    #1 ram_ack = 1'b1;
    @(posedge clk);
    #1 ram_ack = 1'b0;
    wait_ready("sw_exec_ack_ready");

    // SW: ack on exactly the last allowed MEM cycle wins over the fault
    repeat (5) push_exp("sw_ack_limit", 0, 0, 1, 0, 1, 2'b00, 2'b00, ALU_ADD, 0);
    applyStimulus(OP_SW, 4'h0, 1'b0);
    repeat (4) @(posedge clk);
    #1 ram_ack = 1'b1;
    @(posedge clk);
    #1 ram_ack = 1'b0;
    @(negedge clk);
    check_status("sw_ack_limit_idle", 1'b1, 1'b0);

    // Illegal opcode
`ifdef CONTROL_SEQ_ILLEGAL_TRAP_EN
    applyStimulus(4'd9, 4'hB, 1'b0);
    @(negedge clk);
    check_status("illegal_trap", 1'b0, 1'b1);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
`else
    push_exp("illegal_nop", 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'hB, 0);
    applyStimulus(4'd9, 4'hB, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_status("illegal_nop_idle", 1'b1, 1'b0);
`endif

    // Reset while LW sits in MEM aborts it; a new instruction is then accepted
    repeat (2) push_exp("lw_aborted", 0, 1, 0, 1, 1, 2'b00, 2'b00, ALU_ADD, 0);
    applyStimulus(OP_LW, 4'd1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check_status("reset_in_mem", 1'b1, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    push_exp("alu_after_reset", 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'd3, 0);
    applyStimulus(OP_ALU, 4'd3, 1'b0);
    wait_ready("after_reset_ready");

    // SW never acked: four MEM cycles then sticky fault
    repeat (5) push_exp("sw_timeout", 0, 0, 1, 0, 1, 2'b00, 2'b00, ALU_ADD, 0);
    applyStimulus(OP_SW, 4'h5, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_status("sw_timeout_fault", 1'b0, 1'b1);
    applyStimulus(OP_ALU, 4'd1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_status("fault_sticky", 1'b0, 1'b1);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check_status("fault_cleared", 1'b1, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
